i2s_audio_tx: RTL
=================

Name: i2s_audio_tx

Overview:
Buffered I2S serializer for the final stage of the audio path. It accepts signed 16-bit stereo sample pairs through a valid/ready handshake and stores them in a small FIFO. It generates bit clock, word select and serial data for the headphone codec or amplifier (hp_bck/hp_ws/hp_din). It also reports underrun so the mixer upstream can be checked for rate mismatch.

Parameters:
CLK_HZ, 28542800, system clock frequency in Hz.
SAMPLE_HZ, 24000, output sample (frame) rate in Hz.
FIFO_DEPTH, 4, stereo-pair entries; power of two, 2..16.
HALF_DIV, CLK_HZ/(SAMPLE_HZ*64), clk cycles per BCK half-period; 18 at defaults; must be ≥2.

Ports:
clk  in  1  system clock; all logic is synchronous to it.
pll_lock  in  1  asynchronous active-low reset (low = reset).
s_valid  in  1  sample pair offered.
s_ready  out  1  FIFO can accept; equals !full.
s_left  in  16  left sample, two's complement.
s_right  in  16  right sample, two's complement.
mute  in  1  transmit zeros; FIFO still drains.
hp_bck  out  1  I2S bit clock.
hp_ws  out  1  word select; 0 = left, 1 = right.
hp_din  out  1  serial data, MSB first.
underrun  out  1  one-clk pulse when a frame starts with the FIFO empty.
fifo_level  out  clog2(FIFO_DEPTH)+1  current entry count.

Behaviour:
- Reset (pll_lock low, asynchronous):
  - hp_bck=0, hp_ws=0, hp_din=0, underrun=0, fifo_level=0, s_ready=0.
  - Divider count=0, bit_cnt=31, shift register=0, FIFO pointers cleared.
  - s_ready goes to 1 on the first clk edge after reset is released.
- Divider:
  - Counts 0..HALF_DIV-1. At terminal count it wraps to 0 and toggles hp_bck.
  - BCK period is 2*HALF_DIV clk cycles (36 at defaults).
  - fall_tick is the cycle in which hp_bck changes 1->0.
- Frame:
  - bit_cnt (5 bits) increments on every fall_tick and wraps 31->0.
  - hp_ws, hp_din and bit_cnt are registered and update only on fall_tick, so they are stable across each rising BCK edge.
  - hp_ws = new bit_cnt[4].
- Frame load, on the fall_tick where bit_cnt wraps 31->0:
  - FIFO not empty: pop one pair. Load shift register {L,R} (32 bits), or 32'h0 when mute=1.
  - FIFO empty: load the underrun value (see Optional Feature) and pulse underrun for exactly one clk.
- Philips format, one-bit delay:
  - On each fall_tick, hp_din = the shift register bit at index 31-((bit_cnt-1) mod 32).
  - At bit_cnt=0, hp_din carries the previous frame's right-channel LSB; the left MSB appears at bit_cnt=1.
  - The previous frame's bit 0 is kept in a 1-bit register for this purpose.
- FIFO handshake:
  - Push occurs when s_valid && s_ready.
  - Simultaneous push and pop while full: the pop frees a slot but s_ready is computed from registered full, so the push is refused that cycle.
  - Simultaneous push and pop while empty: the pop sees empty (underrun), the push is stored, and the level ends at 1.
  - fifo_level is registered and exact after every cycle.
- Inputs:
  - mute is sampled only at frame load.
  - Changing mute mid-frame has no effect until the next frame.
- Reset mid-frame: all outputs return to reset values immediately and FIFO contents are discarded.

Optional Feature:
Macro I2S_HOLD_LAST_EN.
- Defined: on underrun, the frame reloads the last successfully popped pair, or zeros if none has been popped since reset. This avoids clicks. The underrun pulse still fires.
- Undefined: on underrun the frame is all zeros and the hold register is not synthesized.
- Mute overrides both cases.

Test Plan:
- Reset release, idle, no samples:
  - First hp_bck rise occurs 18 clk after release; period is 36 clk.
  - underrun pulses every 32*36 = 1152 clk.
  - hp_din stays 0.
- Push L=16'h8001, R=16'h1234, then observe one frame:
  - hp_ws=0 for bits 0..15 and 1 for bits 16..31.
  - hp_din at bit_cnt 1..16 = 1000_0000_0000_0001.
  - hp_din at bit_cnt 17..31 plus next-frame bit 0 = 0001_0010_0011_0100.
- Push 5 pairs back-to-back with no frame boundary:
  - s_ready drops after the 4th accept; fifo_level=4; the 5th push is held.
  - After the next frame load: level=3, s_ready=1, the 5th push is accepted.
- Queue 1 pair, then starve for 2 frames:
  - First frame transmits the pair; second frame asserts underrun for one clk.
  - Second frame hp_din = zeros (macro undefined) or a repeat of the pair (I2S_HOLD_LAST_EN).
- Assert mute=1 before a frame load with the FIFO holding 16'h7FFF/16'h7FFF:
  - Frame data is all zeros; fifo_level decrements by 1.
- Drop pll_lock at bit_cnt=20 with fifo_level=3:
  - Outputs go to 0 asynchronously (before the next clk edge); fifo_level=0.
  - After release, the first loaded frame underruns.

Source files
------------

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: FIFO-buffered 16-bit stereo Philips I2S transmitter.
// Define I2S_HOLD_LAST_EN to repeat the last popped pair on underrun.
module i2s_audio_tx #(
   parameter int  CLK_HZ     = 28542800,
   parameter int  SAMPLE_HZ  = 24000,
   parameter int  FIFO_DEPTH = 4,
   parameter int  HALF_DIV   = CLK_HZ / (SAMPLE_HZ * 64),
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          pll_lock,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [15:0]   s_left,
   input  logic [15:0]   s_right,
   input  logic          mute,
   output logic          hp_bck,
   output logic          hp_ws,
   output logic          hp_din,
   output logic          underrun,
   output logic [LW-1:0] fifo_level
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(HALF_DIV);

   if (HALF_DIV < 2) begin : g_bad_div
      $error("i2s_audio_tx: HALF_DIV must be >= 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
       (1 << PW) != FIFO_DEPTH) begin : g_bad_depth
      $error("i2s_audio_tx: FIFO_DEPTH must be a power of two in 2..16");
   end

   logic [CW-1:0] div_cnt;
   logic          div_tc;
   logic          fall_tick;
   logic [4:0]    bit_cnt;
   logic [4:0]    bit_nxt;
   logic [31:0]   shreg;
   logic          active;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          load;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [31:0]   pair_out;
   logic [31:0]   idle_data;
   logic [31:0]   frame_data;

   assign div_tc    = div_cnt == CW'(HALF_DIV - 1);
   assign fall_tick = div_tc && hp_bck;
   assign bit_nxt   = bit_cnt + 5'd1;
   assign load      = fall_tick && (bit_cnt == 5'd31);

   assign full     = fifo_level == LW'(FIFO_DEPTH);
   assign empty    = fifo_level == '0;
   assign s_ready  = active && !full;
   assign push     = s_valid && s_ready;
   assign pop      = load && !empty;
   assign pair_out = mem[rd_ptr];

`ifdef I2S_HOLD_LAST_EN
   logic [31:0] hold_q;

   always_ff @(posedge clk or negedge pll_lock) begin
      if (!pll_lock) begin
         hold_q <= '0;
      end else if (pop) begin
         hold_q <= pair_out;
      end
   end

   assign idle_data = hold_q;
`else
   assign idle_data = '0;
`endif

   assign frame_data = mute  ? '0 :
                       empty ? idle_data : pair_out;

   // Storage carries no reset; only pointers and level define contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {s_left, s_right};
      end
   end

   always_ff @(posedge clk or negedge pll_lock) begin
      if (!pll_lock) begin
         active     <= 1'b0;
         div_cnt    <= '0;
         hp_bck     <= 1'b0;
         hp_ws      <= 1'b0;
         hp_din     <= 1'b0;
         underrun   <= 1'b0;
         bit_cnt    <= 5'd31;
         shreg      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         active   <= 1'b1;
         div_cnt  <= div_tc ? '0 : div_cnt + 1'b1;
         underrun <= load && empty;
         if (div_tc) begin
            hp_bck <= !hp_bck;
         end
         // One-bit delay: the old LSB goes out while the new frame loads.
         if (fall_tick) begin
            bit_cnt <= bit_nxt;
            hp_ws   <= bit_nxt[4];
            if (load) begin
               hp_din <= shreg[0];
               shreg  <= frame_data;
            end else begin
               hp_din <= shreg[5'd0 - bit_nxt];
            end
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
      end
   end

endmodule
